// File: rtl/li_sched.sv
`default_nettype none
// li_sched: timestep sequencer for a spiking layer with lateral inhibition.
// It counts winner spikes per neuron, then picks the classified neuron by argmax.
module li_sched #(
   parameter int N       = 8,
   parameter int T_STEPS = 16,
   parameter int CW      = 8,
   parameter int TMO     = 31
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_sample,
   output logic                     busy,
   output logic                     layer_start,
   input  logic                     layer_done,
   output logic                     li_start,
   input  logic                     li_valid,
   input  logic [N-1:0]             li_won_lost,
   input  logic                     li_first_spike,
   output logic [N-1:0]             pot_reset,
   output logic                     done,
   output logic [$clog2(N+1)-1:0]   winner,
   output logic                     timeout_err
);

   localparam int WW = $clog2(N+1);
   localparam int SW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = $clog2(TMO + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LAYER, S_WAIT_LAYER, S_LI, S_WAIT_LI, S_UPDATE, S_SCAN, S_FINISH
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt [N];
   logic [7:0]      step;
   logic [TW-1:0]   wcnt;
   logic [N-1:0]    cap_wl;
   logic            cap_fs;
   logic [SW-1:0]   sidx;
   logic [CW-1:0]   best_val;
   logic [WW-1:0]   best_idx;
   logic [SW-1:0]   lsb_idx;
   logic            lsb_any;

   logic            wait_tmo;
   logic            step_last;
   logic            scan_last;
   logic            scan_gt;
   logic [WW-1:0]   scan_best;

   assign wait_tmo  = (wcnt == TW'(TMO - 1));
   assign step_last = (step == 8'(T_STEPS - 1));
   assign scan_last = (sidx == SW'(N - 1));
   assign scan_gt   = (cnt[sidx] > best_val);
   assign scan_best = scan_gt ? WW'(sidx) : best_idx;
   assign busy      = (state != S_IDLE);

   // Descending loop so the lowest set bit is the last one written.
   always_comb begin
      lsb_idx = '0;
      lsb_any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (cap_wl[i]) begin
            lsb_idx = SW'(i);
            lsb_any = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      layer_start = 1'b0;
      li_start    = 1'b0;
      done        = 1'b0;
      pot_reset   = '0;
      case (state)
         S_IDLE:       if (start_sample) state_nx = S_LAYER;
         S_LAYER: begin
            layer_start = 1'b1;
            state_nx    = S_WAIT_LAYER;
         end
         S_WAIT_LAYER: begin
            if (layer_done)    state_nx = S_LI;
            else if (wait_tmo) state_nx = S_FINISH;
         end
         S_LI: begin
            li_start = 1'b1;
            state_nx = S_WAIT_LI;
         end
         S_WAIT_LI: begin
            if (li_valid)      state_nx = S_UPDATE;
            else if (wait_tmo) state_nx = S_FINISH;
         end
         S_UPDATE: begin
            pot_reset = {N{cap_fs}};
            state_nx  = step_last ? S_SCAN : S_LAYER;
         end
         S_SCAN:       if (scan_last) state_nx = S_FINISH;
         S_FINISH: begin
            // An aborted presentation also flushes every membrane potential.
            done = 1'b1;
            if (timeout_err) pot_reset = '1;
            state_nx = S_IDLE;
         end
         default:      state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         for (int i = 0; i < N; i++) cnt[i] <= '0;
         step        <= '0;
         wcnt        <= '0;
         cap_wl      <= '0;
         cap_fs      <= 1'b0;
         sidx        <= '0;
         best_val    <= '0;
         best_idx    <= WW'(N);
         winner      <= WW'(N);
         timeout_err <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (start_sample) begin
                  for (int i = 0; i < N; i++) cnt[i] <= '0;
                  step        <= '0;
                  timeout_err <= 1'b0;
               end
            end
            S_LAYER, S_LI: wcnt <= '0;
            S_WAIT_LAYER, S_WAIT_LI: begin
               if (state == S_WAIT_LI && li_valid) begin
                  cap_wl <= li_won_lost;
                  cap_fs <= li_first_spike;
               end else if (!(state == S_WAIT_LAYER && layer_done)) begin
                  if (wait_tmo) begin
                     timeout_err <= 1'b1;
                     winner      <= WW'(N);
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
               end
            end
            S_UPDATE: begin
               if (cap_fs && lsb_any && (cnt[lsb_idx] != {CW{1'b1}}))
                  cnt[lsb_idx] <= cnt[lsb_idx] + 1'b1;
               if (step_last) begin
                  sidx     <= '0;
                  best_val <= '0;
                  best_idx <= WW'(N);
               end else begin
                  step <= step + 1'b1;
               end
            end
            S_SCAN: begin
               // Strict compare keeps the lowest index on ties; all-zero stays at N.
               if (scan_gt) begin
                  best_val <= cnt[sidx];
                  best_idx <= WW'(sidx);
               end
               sidx <= sidx + 1'b1;
               if (scan_last) winner <= scan_best;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_li_sched.sv
`default_nettype none
// tb_li_sched: directed vector bench for li_sched with a scripted layer/LI responder.
module tb_li_sched;

   logic       clk = 1'b0;
   logic       rst;
   always #5 clk = ~clk;

   logic       st1, ld1, lv1, fs1, st2, ld2, lv2, fs2;
   logic [7:0] wl1, wl2;
   logic       busy1, ls1, lis1, done1, te1, busy2, ls2, lis2, done2, te2;
   logic [7:0] pr1, pr2;
   logic [3:0] win1, win2;

   li_sched #(.N(8), .T_STEPS(4), .CW(8), .TMO(31)) dut (
      .clk(clk), .rst(rst), .start_sample(st1), .busy(busy1), .layer_start(ls1),
      .layer_done(ld1), .li_start(lis1), .li_valid(lv1), .li_won_lost(wl1),
      .li_first_spike(fs1), .pot_reset(pr1), .done(done1), .winner(win1),
      .timeout_err(te1));

   li_sched #(.N(8), .T_STEPS(6), .CW(2), .TMO(31)) dut2 (
      .clk(clk), .rst(rst), .start_sample(st2), .busy(busy2), .layer_start(ls2),
      .layer_done(ld2), .li_start(lis2), .li_valid(lv2), .li_won_lost(wl2),
      .li_first_spike(fs2), .pot_reset(pr2), .done(done2), .winner(win2),
      .timeout_err(te2));

   int checks = 0;
   int errors = 0;
   int done_n [2];
   int prff_n [2];
   int prbad_n[2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         done_n[i] = 0; prff_n[i] = 0; prbad_n[i] = 0;
      end
   end

   always @(negedge clk) begin
      if (done1) done_n[0]++;
      if (done2) done_n[1]++;
      if (pr1 == 8'hFF) prff_n[0]++; else if (pr1 != 8'h00) prbad_n[0]++;
      if (pr2 == 8'hFF) prff_n[1]++; else if (pr2 != 8'h00) prbad_n[1]++;
   end

   typedef struct {
      logic [7:0][7:0] wl;
      logic [7:0]      fs;
      logic [3:0]      win;
      int              pr;
      bit              spur;
   } vec_t;

   vec_t tbl[7];

   function automatic vec_t mk(input logic [7:0] w0, w1, w2, w3, input logic [3:0] f,
                               input logic [3:0] w, input int p, input bit s);
      vec_t v;
      v.wl   = {32'h0, w3, w2, w1, w0};
      v.fs   = {4'h0, f};
      v.win  = w;
      v.pr   = p;
      v.spur = s;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic sig(input int which, input bit sel);
      case (which)
         0:       return sel ? ls2 : ls1;
         1:       return sel ? lis2 : lis1;
         default: return sel ? done2 : done1;
      endcase
   endfunction

   task automatic set_in(input bit sel, input logic s, d, v, f, input logic [7:0] w);
      if (sel) begin st2 = s; ld2 = d; lv2 = v; fs2 = f; wl2 = w; end
      else     begin st1 = s; ld1 = d; lv1 = v; fs1 = f; wl1 = w; end
   endtask

   task automatic wait_sig(input int which, input bit sel, output bit got);
      got = 1'b0;
      for (int i = 0; i < 120; i++) begin
         if (sig(which, sel)) begin
            got = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   // Responds to layer_start/li_start with the scripted per-step replies.
   task automatic run_sample(input bit sel, input int ns, input logic [7:0][7:0] wl,
                             input logic [7:0] fs, input bit spur,
                             input int exp_win, input int exp_pr);
      int d0, p0, b0;
      bit got;
      d0 = done_n[sel]; p0 = prff_n[sel]; b0 = prbad_n[sel];
      set_in(sel, 1, 0, 0, 0, 8'h00);
      @(negedge clk);
      set_in(sel, 0, 0, 0, 0, 8'h00);
      for (int s = 0; s < ns; s++) begin
         wait_sig(0, sel, got);
         if (!got) begin chk("layer_start_seen", 0, 1); return; end
         if (spur && s == 0) begin
            @(negedge clk);
            set_in(sel, 1, 0, 1, 1, 8'h01);
            @(negedge clk);
            set_in(sel, 0, 0, 0, 0, 8'h00);
         end else begin
            repeat (1 + s % 2) @(negedge clk);
         end
         set_in(sel, 0, 1, 0, 0, 8'h00);
         @(negedge clk);
         set_in(sel, 0, 0, 0, 0, 8'h00);
         wait_sig(1, sel, got);
         if (!got) begin chk("li_start_seen", 0, 1); return; end
         repeat (1 + (s + 1) % 2) @(negedge clk);
         set_in(sel, 0, 0, 1, fs[s], wl[s]);
         @(negedge clk);
         set_in(sel, 0, 0, 0, 0, 8'h00);
      end
      wait_sig(2, sel, got);
      if (!got) begin chk("done_seen", 0, 1); return; end
      chk("winner", int'(sel ? win2 : win1), exp_win);
      chk("timeout_err_clear", int'(sel ? te2 : te1), 0);
      @(negedge clk);
      chk("busy_after_done", int'(sel ? busy2 : busy1), 0);
      @(negedge clk);
      chk("winner_hold", int'(sel ? win2 : win1), exp_win);
      chk("done_pulses", done_n[sel] - d0, 1);
      chk("pot_reset_ff_cycles", prff_n[sel] - p0, exp_pr);
      chk("pot_reset_partial", prbad_n[sel] - b0, 0);
   endtask

   initial begin
      int  d0, n;
      bit  got;

      tbl[0] = mk(8'h04, 8'h04, 8'h02, 8'h00, 4'b0111, 4'd2, 3, 0);
      tbl[1] = mk(8'h02, 8'h20, 8'h02, 8'h20, 4'b1111, 4'd1, 4, 0);
      tbl[2] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b0000, 4'd8, 0, 0);
      tbl[3] = mk(8'h18, 8'h18, 8'h10, 8'h81, 4'b1111, 4'd3, 4, 0);
      tbl[4] = mk(8'h00, 8'h00, 8'h00, 8'h00, 4'b1111, 4'd8, 4, 0);
      tbl[5] = mk(8'h00, 8'h00, 8'h00, 8'h80, 4'b1000, 4'd7, 1, 0);
      tbl[6] = mk(8'h40, 8'h01, 8'h01, 8'h40, 4'b1111, 4'd0, 4, 1);

      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 8'h00);
      set_in(1, 0, 0, 0, 0, 8'h00);
      repeat (2) @(negedge clk);
      chk("rst_busy", busy1, 0);
      chk("rst_layer_start", ls1, 0);
      chk("rst_li_start", lis1, 0);
      chk("rst_done", done1, 0);
      chk("rst_pot_reset", pr1, 0);
      chk("rst_timeout_err", te1, 0);
      chk("rst_winner", win1, 8);
      chk("rst_winner_dut2", win2, 8);
      rst = 1'b0;
      @(negedge clk);

      foreach (tbl[i])
         run_sample(0, 4, tbl[i].wl, tbl[i].fs, tbl[i].spur, tbl[i].win, tbl[i].pr);

      // Withheld layer_done: abort after the wait budget.
      d0 = done_n[0];
      set_in(0, 1, 0, 0, 0, 8'h00);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 8'h00);
      wait_sig(0, 0, got);
      chk("tmo_layer_start_seen", got, 1);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n++;
         if (done1) break;
      end
      chk("tmo_done_seen", done1, 1);
      chk("tmo_latency_in_range", (n >= 31 && n <= 33) ? 1 : 0, 1);
      chk("tmo_timeout_err", te1, 1);
      chk("tmo_winner", win1, 8);
      chk("tmo_pot_reset", pr1, 8'hFF);
      @(negedge clk);
      chk("tmo_busy_after", busy1, 0);
      chk("tmo_sticky", te1, 1);
      chk("tmo_done_pulses", done_n[0] - d0, 1);

      run_sample(0, 4, tbl[0].wl, tbl[0].fs, 0, 2, 3);

      // Reset while waiting for the LI response.
      d0 = done_n[0];
      set_in(0, 1, 0, 0, 0, 8'h00);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 8'h00);
      wait_sig(0, 0, got);
      @(negedge clk);
      set_in(0, 0, 1, 0, 0, 8'h00);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 8'h00);
      wait_sig(1, 0, got);
      chk("mid_li_start_seen", got, 1);
      @(negedge clk);
      chk("mid_busy_before_rst", busy1, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy1, 0);
      chk("mid_rst_winner", win1, 8);
      chk("mid_rst_pot_reset", pr1, 0);
      chk("mid_rst_done", done1, 0);
      chk("mid_rst_li_start", lis1, 0);
      chk("mid_rst_layer_start", ls1, 0);
      chk("mid_rst_timeout_err", te1, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      set_in(0, 0, 0, 1, 1, 8'h04);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 8'h00);
      repeat (3) @(negedge clk);
      chk("mid_rst_idle_after", busy1, 0);
      chk("mid_rst_no_done", done_n[0] - d0, 0);

      run_sample(0, 4, tbl[3].wl, tbl[3].fs, 0, 3, 4);

      // CW=2: neuron 3 wins five steps and must saturate at 3, beating neuron 1.
      run_sample(1, 6, {8'h00, 8'h00, 8'h02, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08},
                 8'b0011_1111, 0, 3, 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
